// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-ported synchronous memory
// Optional MEM_ARB_FIXED_PRIO_EN: port 0 always wins contention instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    grant0;
    logic                    grant1;
    logic                    accept;
    logic                    accept_port;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    cap_wr;
    logic                    cap_port;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
`else
    // last_grant names the port accepted most recently; the other port wins a tie.
    logic last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= accept_port;
        end
    end

    assign grant0 = req0_valid & (~req1_valid | last_grant);
`endif

    assign grant1      = req1_valid & ~grant0;
    assign req0_ready  = (state == IDLE) & ~reset & grant0;
    assign req1_ready  = (state == IDLE) & ~reset & grant1;
    assign accept      = req0_ready | req1_ready;
    assign accept_port = req1_ready;

    always_comb begin
        sel_wr    = req0_wr;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (accept_port) begin
            sel_wr    = req1_wr;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = cap_wr ? IDLE : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are loaded on acceptance so they are live exactly during ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            cap_wr     <= 1'b0;
            cap_port   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            if (accept) begin
                cap_port  <= accept_port;
                cap_wr    <= sel_wr;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_wr_en <= sel_wr;
                mem_rd_en <= ~sel_wr;
            end
            if (state == WAIT) begin
                if (cap_port) begin
                    rsp1_rdata <= mem_rdata;
                end else begin
                    rsp0_rdata <= mem_rdata;
                end
            end
        end
    end

    assign rsp0_valid = (state == RESP) & ~cap_port;
    assign rsp1_valid = (state == RESP) & cap_port;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a small synchronous memory model
module tb_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic          rst;
        logic          v0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
    } in_t;

    typedef struct packed {
        logic          r0;
        logic          r1;
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rv0;
        logic [DW-1:0] rd0;
        logic          rv1;
        logic [DW-1:0] rd1;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_wr, req0_ready, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_wr, req1_ready, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en, mem_rd_en;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: mem[i] = 0x10+i except mem[3] = 0xA5; read data one cycle after mem_rd_en.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
            mem[3]    <= 8'hA5;
            mem_rdata <= '0;
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem[mem_addr];
        end
    end

    out_t cur_out;
    assign cur_out = '{req0_ready, req1_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
                       rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input in_t v);
        reset      = v.rst;
        req0_valid = v.v0; req0_wr = v.w0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_wr = v.w1; req1_addr = v.a1; req1_wdata = v.d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [16];
    in_t  idle_in;
    in_t  both_rd;
    logic gp;

    initial begin
        idle_in = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00};
        both_rd = '{1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00};
        //          rst  v0  w0  a0  d0      v1  w1  a1  d1        r0  r1  we  re  addr wdata  rv0 rd0     rv1 rd1
        vecs[0]  = '{'{1, 1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00}};
        vecs[1]  = '{'{0, 1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00}, '{1, 0, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00}};
        vecs[2]  = '{'{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 1, 4'h3, 8'h00, 0, 8'h00, 0, 8'h00}};
        vecs[3]  = '{'{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 0, 4'h3, 8'h00, 0, 8'h00, 0, 8'h00}};
        vecs[4]  = '{'{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 0, 4'h3, 8'h00, 1, 8'hA5, 0, 8'h00}};
        vecs[5]  = '{'{0, 0, 0, 4'h0, 8'h00, 1, 1, 4'h7, 8'h3C}, '{0, 1, 0, 0, 4'h3, 8'h00, 0, 8'hA5, 0, 8'h00}};
        vecs[6]  = '{'{0, 1, 0, 4'h7, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 1, 0, 4'h7, 8'h3C, 0, 8'hA5, 0, 8'h00}};
        vecs[7]  = '{'{0, 1, 0, 4'h7, 8'h00, 1, 0, 4'h7, 8'h00}, '{1, 0, 0, 0, 4'h7, 8'h3C, 0, 8'hA5, 0, 8'h00}};
        vecs[8]  = '{'{0, 0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00}, '{0, 0, 0, 1, 4'h7, 8'h00, 0, 8'hA5, 0, 8'h00}};
        vecs[9]  = '{'{0, 0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00}, '{0, 0, 0, 0, 4'h7, 8'h00, 0, 8'hA5, 0, 8'h00}};
        vecs[10] = '{'{0, 0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00}, '{0, 0, 0, 0, 4'h7, 8'h00, 1, 8'h3C, 0, 8'h00}};
        vecs[11] = '{'{0, 0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00}, '{0, 1, 0, 0, 4'h7, 8'h00, 0, 8'h3C, 0, 8'h00}};
        vecs[12] = '{'{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 1, 4'h7, 8'h00, 0, 8'h3C, 0, 8'h00}};
        vecs[13] = '{'{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 0, 4'h7, 8'h00, 0, 8'h3C, 0, 8'h00}};
        vecs[14] = '{'{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 0, 4'h7, 8'h00, 0, 8'h3C, 1, 8'h3C}};
        vecs[15] = '{'{0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00}, '{0, 0, 0, 0, 4'h7, 8'h00, 0, 8'h3C, 0, 8'h3C}};

        drive('{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00});
        next_cycle();

        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].i);
            @(negedge clk);
            check($sformatf("vec%0d", k), 64'(cur_out), 64'(vecs[k].o));
            next_cycle();
        end

        // Both ports reading continuously: one grant every 4 cycles.
        for (int k = 0; k < 16; k++) begin
            drive(both_rd);
`ifdef MEM_ARB_FIXED_PRIO_EN
            gp = 1'b0;
`else
            gp = 1'(k / 4);
`endif
            @(negedge clk);
            check($sformatf("contend%0d", k), {60'b0, req0_ready, req1_ready, rsp0_valid, rsp1_valid},
                  {60'b0, (k % 4 == 0) & ~gp, (k % 4 == 0) & gp, (k % 4 == 3) & ~gp, (k % 4 == 3) & gp});
            if (k % 4 == 3)
                check($sformatf("contend_rdata%0d", k), 64'(gp ? rsp1_rdata : rsp0_rdata),
                      64'(gp ? 8'h15 : 8'hA5));
            next_cycle();
        end

        drive('{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00});
        @(negedge clk);
        check("port1_after_drop", {62'b0, req0_ready, req1_ready}, 64'b01);
        next_cycle();
        drive(idle_in);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("port1_after_drop_rsp", {55'b0, rsp1_valid, rsp1_rdata}, {55'b0, 1'b1, 8'h15});
        next_cycle();

        // Reset while a port-0 read is in WAIT.
        drive('{1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00});
        @(negedge clk);
        check("rst_accept", 64'(req0_ready), 64'd1);
        next_cycle();
        drive(idle_in);
        @(negedge clk);
        check("rst_issue", {59'b0, mem_rd_en, mem_addr}, {59'b0, 1'b1, 4'h3});
        next_cycle();
        drive('{1'b1, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00});
        @(negedge clk);
        check("rst_ready_low", {62'b0, req0_ready, req1_ready}, 64'b0);
        next_cycle();
        drive(idle_in);
        @(negedge clk);
        check("rst_outputs", 64'(cur_out), 64'b0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("rst_quiet%0d", k), {61'b0, rsp0_valid, mem_rd_en, mem_wr_en}, 64'b0);
        end
        next_cycle();
        drive(both_rd);
        @(negedge clk);
        check("rst_first_contention", {62'b0, req0_ready, req1_ready}, 64'b10);
        next_cycle();
        drive(idle_in);
        next_cycle();
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 reqN_valid  in  1  (N=0,1) requester N has a transaction pending.
REQ-006 reqN_wr  in  1  1=write, 0=read.
REQ-007 reqN_addr  in  ADDR_WIDTH  target address.
REQ-008 reqN_wdata  in  DATA_WIDTH  write data.
REQ-009 reqN_ready  out  1  transaction accepted this cycle.
REQ-010 rspN_valid  out  1  read data valid, one-cycle pulse.
REQ-011 rspN_rdata  out  DATA_WIDTH  read data.
REQ-012 mem_addr  out  ADDR_WIDTH; mem_wr_en  out  1; mem_rd_en  out  1; mem_wdata  out  DATA_WIDTH. All registered.
REQ-013 mem_rdata  in  DATA_WIDTH  valid in the cycle after the cycle mem_rd_en is high.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: reqN_ready asserted combinationally for exactly the winning port with reqN_valid=1; both ready low when no valid or not in IDLE.
REQ-016 Acceptance = reqN_valid & reqN_ready at cycle T; addr/wr/wdata/port captured at T; FSM -> ISSUE.
REQ-017 ISSUE (T+1): mem_addr/mem_wdata = captured values; mem_wr_en=1 for writes, mem_rd_en=1 for reads; never both.
REQ-018 Write: ISSUE -> IDLE; no response; next acceptance possible at T+2.
REQ-019 Read: ISSUE -> WAIT (T+2) capturing mem_rdata into response register -> RESP (T+3): rspN_valid=1 for the captured port only, rspN_rdata=captured data -> IDLE; next acceptance possible at T+4.
REQ-020 rspN_rdata SHALL hold last returned value when rspN_valid=0.
REQ-021 Arbitration (default): round-robin; on simultaneous valid, grant port opposite last_grant; last_grant updates only on acceptance.
REQ-022 Single valid requester SHALL be granted regardless of last_grant.
REQ-023 Requests arriving while not IDLE SHALL wait (ready low); requester holds valid and fields stable until accepted.
REQ-024 At most one transaction in flight; mem_wr_en/mem_rd_en low outside ISSUE.

Reset
REQ-025 reset=1 at a clock edge: FSM=IDLE, last_grant=1 (port 0 wins first contention), mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0.
REQ-026 Reset mid-transaction SHALL abort it: no mem strobe and no response pulse after the reset edge.
REQ-027 reqN_ready SHALL be 0 while reset=1.

Configuration
REQ-028 Macro MEM_ARB_FIXED_PRIO_EN defined: port 0 always wins contention, last_grant unused.
REQ-029 Macro undefined: round-robin per REQ-021.

Verification
REQ-030 req0 read addr 3 (mem[3]=0xA5) alone -> ready0 at T, mem_rd_en T+1 addr 3, rsp0_valid T+3 rdata 0xA5, rsp1_valid stays 0.
REQ-031 req1 write addr 7 data 0x3C -> mem_wr_en=1, mem_addr=7, mem_wdata=0x3C at T+1; then req1 read addr 7 -> rsp1_rdata 0x3C.
REQ-032 Both valid continuously, reads, round-robin -> grants 0,1,0,1 every 4 cycles, no gaps beyond FSM latency.
REQ-033 Same as REQ-032 with MEM_ARB_FIXED_PRIO_EN -> every grant to port 0; port 1 granted only after req0_valid drops.
REQ-034 reset=1 in WAIT of a read -> next cycle FSM IDLE, rsp0_valid never pulses, all mem outputs 0.
REQ-035 req0 arrives during a port-1 write's ISSUE -> ready0 low until IDLE, accepted at T+2.
